mux8to1_sel: RTL and testbench
==============================

Name: mux8to1_sel

Overview:
- 8-to-1 selector. Three select bits S2..S0 choose one of eight data inputs D0..D7.
- Provides a purely combinational output `out` and a registered copy `out_r` for downstream timing closure.
- Used as a leaf datapath block and as a golden reference for post-route netlist equivalence.

Parameters:
- WIDTH, 1, bit width of each data input and of both outputs.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- D0..D7  input  WIDTH each  data inputs; index = binary {S2,S1,S0}.
- S0  input  1  select LSB.
- S1  input  1  select middle bit.
- S2  input  1  select MSB.
- out  output  WIDTH  combinational selected data.
- out_r  output  WIDTH  registered selected data.

Behaviour:
- sel = {S2,S1,S0} (3 bits, unsigned). out = D[sel]:
  - sel=0 → D0, sel=1 → D1, … sel=7 → D7.
- out is purely combinational and settles within the same cycle as any input change. It has no dependence on clk or rst_n.
- out is fully decoded: all 8 codes are legal, there is no default/undefined branch, and no latch is inferred.
- out_r:
  - rst_n low (asynchronous, takes effect immediately): out_r = 0.
  - rst_n high: on every rising clk edge, out_r <= out. Latency is 1 cycle.
- Reset release: first capture is on the first rising edge with rst_n high. Deassertion is expected to be synchronized externally.
- Changes to data or select in the middle of a cycle appear on out immediately and on out_r at the next rising edge only.
- Simultaneous change of select and data: out reflects the new select applied to the new data; there is no priority between them.
- Width rule: every D input, out and out_r are exactly WIDTH bits, with no extension or truncation.

Optional Feature:
- Macro MUX8_HOLD_EN.
- Defined:
  - Adds input port hold (1 bit, active-high).
  - While hold=1, out_r keeps its value on rising edges.
  - Reset still forces out_r to 0 regardless of hold.
  - out (combinational) is unaffected by hold.
- Undefined: no hold port; out_r updates every rising edge as above.

Decomposition:
- Package mux8_pkg:
  - localparam N_IN = 8.
  - localparam SEL_W = 3.
  - typedef logic [SEL_W-1:0] sel_t.
- Sub-module mux8_comb (pure combinational 8:1 select, WIDTH-parameterized) is natural. The top adds the select concatenation, the output register and the hold option.

Test Plan:
- Reset: rst_n=0 with D0=1, sel=0 → out_r=0 immediately while out=1. Release rst_n → out_r=1 after the first rising edge.
- Exhaustive select with D0..D7 = 1,0,1,0,1,0,1,0:
  - sel 0..7 stepped every 2 cycles (S0 toggles fastest).
  - out = 1,0,1,0,1,0,1,0.
  - out_r matches out one cycle after each step.
- Walking one: D7=1, all other D=0. Sweep sel 0..7 → out=1 only at sel=7 (S2=S1=S0=1), otherwise 0.
- Mid-cycle data change: sel=3, toggle D3 between clock edges.
  - out follows the toggle immediately.
  - out_r samples the value present at the rising edge only.
  - Toggling D2 or D4 has no effect on out.
- Async reset mid-operation: out_r=1, assert rst_n between clock edges → out_r=0 before the next edge. out still equals D[sel].
- With MUX8_HOLD_EN: out_r=1, set hold=1, change the selection so out=0 → out_r stays 1 for 3 edges. Drop hold → out_r=0 on the next edge.

Source files
------------

// File: rtl/mux8_pkg.sv
// Shared constants and select type for the 8:1 selector.
package mux8_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux8_comb.sv
// Pure combinational 8:1 select. Every select code is decoded explicitly,
// so the output is defined for all inputs and no storage is inferred.
module mux8_comb
  import mux8_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [N_IN-1:0][WIDTH-1:0] i_d,
  input  sel_t                       i_sel,
  output logic [WIDTH-1:0]           o_y
);

  // Full decode of the 3-bit select onto the eight data lanes.
  always_comb begin
    o_y = i_d[0];
    unique case (i_sel)
      3'd0: o_y = i_d[0];
      3'd1: o_y = i_d[1];
      3'd2: o_y = i_d[2];
      3'd3: o_y = i_d[3];
      3'd4: o_y = i_d[4];
      3'd5: o_y = i_d[5];
      3'd6: o_y = i_d[6];
      3'd7: o_y = i_d[7];
    endcase
  end

endmodule

// File: rtl/mux8to1_sel.sv
// 8:1 selector with a combinational output and a one-cycle registered copy.
// Optional build macro MUX8_HOLD_EN adds an active-high 'hold' input that
// freezes the registered output (reset still clears it).
module mux8to1_sel
  import mux8_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic [WIDTH-1:0] D4,
  input  logic [WIDTH-1:0] D5,
  input  logic [WIDTH-1:0] D6,
  input  logic [WIDTH-1:0] D7,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
`ifdef MUX8_HOLD_EN
  input  logic             hold,
`endif
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_r
);

  logic [N_IN-1:0][WIDTH-1:0] w_d;
  sel_t                       w_sel;
  logic [WIDTH-1:0]           w_out;
  logic [WIDTH-1:0]           r_out_r;

  // S2 is the MSB of the lane index; D0 sits in the lowest lane.
  assign w_sel = {S2, S1, S0};
  assign w_d   = {D7, D6, D5, D4, D3, D2, D1, D0};

  mux8_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .i_d   (w_d),
    .i_sel (w_sel),
    .o_y   (w_out)
  );

  assign out = w_out;

  // Capture the selected data each rising edge; async clear on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_r <= '0;
`ifdef MUX8_HOLD_EN
    end else if (!hold) begin
      r_out_r <= w_out;
`else
    end else begin
      r_out_r <= w_out;
`endif
    end
  end

  assign out_r = r_out_r;

endmodule

// File: tb/tb_mux8to1_sel.sv
// Directed bench for mux8to1_sel with a scoreboard queue for out_r.
// Build with +define+MUX8_HOLD_EN to also exercise the hold input.
module tb_mux8to1_sel;

  localparam int W = 1;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] d [8];
  logic         s0, s1, s2;
  logic [W-1:0] out, out_r;
`ifdef MUX8_HOLD_EN
  logic         hold;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] exp_r;

  mux8to1_sel #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D0    (d[0]),
    .D1    (d[1]),
    .D2    (d[2]),
    .D3    (d[3]),
    .D4    (d[4]),
    .D5    (d[5]),
    .D6    (d[6]),
    .D7    (d[7]),
    .S0    (s0),
    .S1    (s1),
    .S2    (s2),
`ifdef MUX8_HOLD_EN
    .hold  (hold),
`endif
    .out   (out),
    .out_r (out_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  function automatic logic [W-1:0] model();
    int idx;
    idx = {s2, s1, s0};
    return d[idx];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_sel(input int s);
    {s2, s1, s0} = 3'(s);
  endtask

  // Push expected out_r for the coming edge, then pop and compare after it.
  task automatic tick(input string tag);
    logic [W-1:0] e;
`ifdef MUX8_HOLD_EN
    if (!hold) exp_r = model();
`else
    exp_r = model();
`endif
    sb.push_back(exp_r);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(tag, out_r, e);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = '0;
    d[0] = 1'b1;
    set_sel(0);
    exp_r = '0;
`ifdef MUX8_HOLD_EN
    hold = 1'b0;
`endif

    // Reset: out_r cleared while combinational out already shows D0.
    #2;
    check("rst_out", out, 1'b1);
    check("rst_out_r", out_r, 1'b0);
    @(posedge clk);
    #1;
    check("rst_out_r_edge", out_r, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("rel_out_r");

    // Exhaustive select with alternating data.
    for (int i = 0; i < 8; i++) d[i] = (i % 2 == 0) ? 1'b1 : 1'b0;
    for (int s = 0; s < 8; s++) begin
      set_sel(s);
      #1;
      check($sformatf("exh_out_%0d", s), out, (s % 2 == 0) ? 1'b1 : 1'b0);
      tick($sformatf("exh_out_r_a_%0d", s));
      tick($sformatf("exh_out_r_b_%0d", s));
    end

    // Walking one on D7.
    for (int i = 0; i < 8; i++) d[i] = '0;
    d[7] = 1'b1;
    for (int s = 0; s < 8; s++) begin
      set_sel(s);
      #1;
      check($sformatf("walk_out_%0d", s), out, (s == 7) ? 1'b1 : 1'b0);
      tick($sformatf("walk_out_r_%0d", s));
    end

    // Mid-cycle data change on the selected lane.
    for (int i = 0; i < 8; i++) d[i] = '0;
    set_sel(3);
    tick("mid_base");
    d[3] = 1'b1; #1; check("mid_tog1", out, 1'b1);
    check("mid_hold_r", out_r, 1'b0);
    d[3] = 1'b0; #1; check("mid_tog0", out, 1'b0);
    d[3] = 1'b1; #1; check("mid_tog1b", out, 1'b1);
    tick("mid_capture");
    d[3] = 1'b0; #1; check("mid_tog0b", out, 1'b0);
    check("mid_r_keeps", out_r, 1'b1);
    d[3] = 1'b1; #1;
    d[2] = 1'b1; #1; check("mid_d2", out, 1'b1);
    d[4] = 1'b0; #1; check("mid_d4", out, 1'b1);
    d[3] = 1'b0; d[2] = 1'b1; d[4] = 1'b1; #1;
    check("mid_neighbours", out, 1'b0);
    d[3] = 1'b1; d[2] = 1'b0; d[4] = 1'b0;
    tick("mid_final");

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_r", out_r, 1'b0);
    check("async_out", out, 1'b1);
    sb.delete();
    exp_r = '0;
    @(posedge clk);
    #1;
    check("async_edge_r", out_r, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("async_release");

`ifdef MUX8_HOLD_EN
    // Hold freezes out_r while the combinational path moves on.
    hold = 1'b1;
    set_sel(2);
    #1;
    check("hold_out", out, 1'b0);
    tick("hold_e1");
    tick("hold_e2");
    tick("hold_e3");
    check("hold_val", out_r, 1'b1);
    hold = 1'b0;
    tick("hold_drop");
    check("hold_drop_val", out_r, 1'b0);
    set_sel(3);
    tick("hold_reload");
    hold = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("hold_rst", out_r, 1'b0);
    sb.delete();
    exp_r = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick("hold_after_rst");
    hold = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
